// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver (and the matching TX block):
//   - CLKS_PER_BIT_DEF : default clocks per bit period
//   - DATA_BITS / STOP_BITS : frame shape (8N1)
//   - uart_state_e : 3-bit FSM state encoding shared by RX and TX
//   - maj3 : 2-of-3 majority helper for oversampled bit decisions
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 87;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned STOP_BITS        = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_CLEAN = 3'd4
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for a single asynchronous input. Resets to 1 so an
// idle-high line does not look like an edge coming out of reset.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   d_i   in  asynchronous input
//   q_o   out synchronised output
// ---------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, idle-high line. Finds the start bit, samples
// each bit at its centre and presents the byte with a one-cycle valid strobe.
// A low stop bit gives a one-cycle framing-error strobe instead.
// Optional build macro: UART_RX_MAJORITY_EN -- data and stop bits are decided
// by a 2-of-3 majority of samples taken at CLKS_PER_BIT-3, -2 and -1.
// Ports:
//   clk          in      system clock
//   rst_n        in      synchronous active-low reset
//   Rx_Serial    in      asynchronous serial line
//   Rx_Byte      out [8] last correctly framed byte
//   Rx_Valid     out     one-cycle pulse, Rx_Byte is new
//   Rx_Frame_Err out     one-cycle pulse, stop bit sampled low
//   Rx_Busy      out     high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Rx_Serial,
    output logic [7:0] Rx_Byte,
    output logic       Rx_Valid,
    output logic       Rx_Frame_Err,
    output logic       Rx_Busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           byte_q,  byte_d;
    logic                 valid_q, valid_d;
    logic                 err_q,   err_d;
    logic                 bit_val;
    logic                 at_last;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (Rx_Serial),
        .q_o   (rx_s)
    );

    assign at_last = (cnt_q == CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_SAMP0 = CNT_W'(CLKS_PER_BIT - 3);

    // Holds the samples from CLKS_PER_BIT-3 and -2; the third sample is the
    // live rx_s at the terminal count, so the decision lands on the same
    // cycle as the single-sample build.
    logic [1:0] samp_q, samp_d;

    always_comb begin
        samp_d = samp_q;
        if ((state_q == ST_DATA || state_q == ST_STOP) &&
            cnt_q >= CNT_SAMP0 && !at_last) begin
            samp_d = {samp_q[0], rx_s};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q <= '0;
        end else begin
            samp_q <= samp_d;
        end
    end

    assign bit_val = maj3(samp_q[1], samp_q[0], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (at_last) begin
                    shift_d[idx_q] = bit_val;
                    cnt_d          = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (bit_val) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_CLEAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CLEAN: begin
                // Wait for the line to return high so a break after a
                // framing error cannot be mistaken for a new start bit.
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign Rx_Byte      = byte_q;
    assign Rx_Valid     = valid_q;
    assign Rx_Frame_Err = err_q;
    assign Rx_Busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx: frame stimulus pushes the expected pulse
// (kind, byte, start-edge cycle) into a queue; a monitor on the falling clock
// edge pops and compares whenever Rx_Valid or Rx_Frame_Err is seen.
// Honours UART_RX_MAJORITY_EN for the centre-glitch frame.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] Rx_Byte;
    logic       Rx_Valid;
    logic       Rx_Frame_Err;
    logic       Rx_Busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rx_Serial    (rx),
        .Rx_Byte      (Rx_Byte),
        .Rx_Valid     (Rx_Valid),
        .Rx_Frame_Err (Rx_Frame_Err),
        .Rx_Busy      (Rx_Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor
    exp_t e;
    always @(negedge clk) begin
        if (Rx_Valid || Rx_Frame_Err) begin
            check("valid_err_exclusive", 32'(Rx_Valid & Rx_Frame_Err), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({Rx_Valid, Rx_Frame_Err}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_is_err", 32'(Rx_Frame_Err), 32'(e.is_err));
                check("rx_byte", 32'(Rx_Byte), 32'(e.data));
                if (!e.is_err) check_range("valid_latency", cyc - e.t0, 826, 832);
            end
        end
    end

    // Drives one frame, one clock per iteration. A glitch inverts the line
    // for the single cycle that lands on each data-bit sample point.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_it,
                              input logic [7:0] exp_byte, input bit exp_err,
                              input bit glitch, input int max_iter);
        logic [9:0] frame;
        logic       v;
        int         iter;
        exp_t       x;
        frame = {stop, d, 1'b0};
        iter  = 0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < CPB; k++) begin
                if (iter == max_iter) return;
                @(posedge clk);
                #1;
                v = frame[b];
                if (glitch && b >= 1 && b <= 8 && k == 44) v = ~v;
                rx = v;
                if (iter == 0 && expect_it) begin
                    x.is_err = exp_err;
                    x.data   = exp_byte;
                    x.t0     = cyc;
                    sb.push_back(x);
                end
                iter++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    logic [7:0] glitch_exp;

    initial begin
`ifdef UART_RX_MAJORITY_EN
        glitch_exp = 8'hC3;
`else
        glitch_exp = 8'h3C;
`endif
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_byte",  32'(Rx_Byte), 32'h00);
        check("reset_valid", 32'(Rx_Valid), 32'd0);
        check("reset_err",   32'(Rx_Frame_Err), 32'd0);
        check("reset_busy",  32'(Rx_Busy), 32'd0);
        idle(50);

        // Single good frame
        send_frame(8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 10*CPB);
        idle(20);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 10*CPB);
        send_frame(8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 10*CPB);
        idle(50);

        // 20-clk low pulse: false start rejected
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("false_start_busy", 32'(Rx_Busy), 32'd1);
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("false_start_idle", 32'(Rx_Busy), 32'd0);
        check("false_start_byte", 32'(Rx_Byte), 32'hFF);
        idle(20);

        // Framing error followed by a held-low break
        send_frame(8'h3C, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 10*CPB);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("break_busy", 32'(Rx_Busy), 32'd1);
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("break_release_idle", 32'(Rx_Busy), 32'd0);
        idle(20);
        send_frame(8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 10*CPB);
        idle(20);

        // Reset during data bit 4 of 0x5A
        send_frame(8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5*CPB + 40);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        rx    = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_byte",  32'(Rx_Byte), 32'h00);
        check("midreset_valid", 32'(Rx_Valid), 32'd0);
        check("midreset_err",   32'(Rx_Frame_Err), 32'd0);
        check("midreset_busy",  32'(Rx_Busy), 32'd0);
        idle(300);
        send_frame(8'h12, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 10*CPB);
        idle(20);

        // One-cycle inverted glitch at each data-bit sample point
        send_frame(8'hC3, 1'b1, 1'b1, glitch_exp, 1'b0, 1'b1, 10*CPB);
        idle(40);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; downstream consumer of the TX serial line (8N1, LSB first, idle high).
- Synchronises the asynchronous serial input and locates the start bit.
- Samples each bit at its centre; presents the received byte with a one-cycle valid strobe to the host logic.
- Flags framing errors (stop bit sampled low).

Parameters:
- CLKS_PER_BIT, 87: clocks per bit period. Must match the TX side; minimum value 8.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-period counter (derived, not overridden).

Ports:
- clk  in  1: system clock.
- rst_n  in  1: reset.
- Rx_Serial  in  1: asynchronous serial line, idle high.
- Rx_Byte  out  8: last correctly framed byte; holds its value until the next good frame.
- Rx_Valid  out  1: one-cycle pulse; Rx_Byte is new this cycle.
- Rx_Frame_Err  out  1: one-cycle pulse; stop bit was sampled 0.
- Rx_Busy  out  1: high in every state except IDLE.

Interface note (already decided): one clock; reset is synchronous and active-low.

Behaviour:
- Reset (rst_n low at a clk edge), values after that edge:
  - state=IDLE; counters 0; shift register 0.
  - Rx_Byte=8'h00; Rx_Valid=0; Rx_Frame_Err=0; Rx_Busy=0.
  - Synchroniser flops preset to 1.
  - Reset mid-frame abandons the frame; no Valid or Err pulse is produced.
- Input path: 2-FF synchroniser produces rx_s. All decisions use rx_s only; Rx_Serial is never sampled directly.
- IDLE: clk_count=0, bit_index=0. When rx_s==0 -> START.
- START: count up to MID=(CLKS_PER_BIT-1)/2 (43 at the default).
  - rx_s==0 at MID -> DATA, clk_count=0.
  - rx_s==1 at MID -> IDLE (glitch rejected; no outputs).
- DATA: at clk_count==CLKS_PER_BIT-1:
  - shift[bit_index] <= rx_s; clk_count <= 0.
  - bit_index 0..7; after bit 7 -> STOP.
  - Otherwise clk_count increments.
- STOP: at clk_count==CLKS_PER_BIT-1, sample rx_s.
  - 1: Rx_Byte <= shift, Rx_Valid=1 for the next cycle.
  - 0: Rx_Frame_Err=1 for the next cycle; Rx_Byte unchanged.
  - Either outcome -> CLEAN.
- CLEAN: one cycle minimum.
  - Exit to IDLE only when rx_s==1. A break or stuck-low line after a framing error must not retrigger reception.
  - After a good frame rx_s is already 1, so CLEAN lasts exactly one cycle.
- Latency: Rx_Valid rises 826-832 clk after the start-bit falling edge on Rx_Serial (default CLKS_PER_BIT). Budget: 9.5 bit periods plus synchroniser and state overhead.
- Back-to-back frames: a start edge arriving in the second half of the stop bit is detected once IDLE is re-entered. Worst case loses ≤3 clk of start-bit phase.
- Rx_Valid and Rx_Frame_Err are never high in the same cycle.
- Counter arithmetic: unsigned CNT_W; compares use CLKS_PER_BIT-1. No wrap occurs because the counter is cleared at terminal count.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each data and stop bit is sampled at clk_count = CLKS_PER_BIT-3, -2 and -1.
  - Bit value = 2-of-3 majority, evaluated at CLKS_PER_BIT-1.
  - A single-cycle glitch at a bit centre is rejected.
  - START check is unchanged.
- Undefined: single sample at CLKS_PER_BIT-1. The 3-bit sample register is absent.
- Latency is identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - CLKS_PER_BIT default.
  - FSM state localparams: IDLE, START, DATA, STOP, CLEAN, 3-bit encoding shared with the TX block.
  - Frame constants: DATA_BITS=8, STOP_BITS=1.
- Natural sub-module: uart_rx_sync. 2-FF synchroniser, reset value 1, reusable by other asynchronous inputs.

Test Plan:
- Idle line, then frame 8'hA5 at 87 clk/bit -> single Rx_Valid pulse 826-832 clk after the falling edge; Rx_Byte=8'hA5; Rx_Frame_Err stays 0.
- Back-to-back frames 8'h00 then 8'hFF, no idle gap -> two Valid pulses 870±2 clk apart, bytes 00 then FF.
- 20-clk low pulse on an idle line -> returns to IDLE by ~47 clk; no Valid or Err; Rx_Busy drops; Rx_Byte unchanged.
- Frame 8'h3C with stop bit 0, line held low a further 300 clk -> one Rx_Frame_Err pulse; Rx_Byte keeps its prior value; Rx_Busy stays high until the line rises; next good frame 8'h81 is received correctly.
- rst_n asserted low for 1 clk during data bit 4 of frame 8'h5A -> all outputs at reset values; no pulse; the following frame 8'h12 is received correctly.
- With UART_RX_MAJORITY_EN: 1-clk inverted glitch at each bit centre of 8'hC3 -> Rx_Byte=8'hC3. Without the macro, the same stimulus gives a corrupted byte (bench checks mismatch).
